// File: rtl/mul_div_if.sv
// Issue/writeback bundle between the issue stage, the iterative mul/div unit
// and the register memory write port.
interface mul_div_if #(
  parameter int B = 32,
  parameter int N = 5
);
  logic         start;
  logic [1:0]   op;
  logic [B-1:0] rs_data1;
  logic [B-1:0] rs_data2;
  logic [N-1:0] rd_addr;
  logic         busy;
  logic         done;
  logic [N-1:0] w_addr;
  logic [B-1:0] w_data;
  logic         write_en;

  // Issue side: drives requests, observes completion and writeback.
  modport master (
    output start, op, rs_data1, rs_data2, rd_addr,
    input  busy, done, w_addr, w_data, write_en
  );

  // Execute unit side.
  modport slave (
    input  start, op, rs_data1, rs_data2, rd_addr,
    output busy, done, w_addr, w_data, write_en
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit. One shift-add (multiply) and one
// restoring-division step are taken per cycle for B cycles; the result selected
// by the latched opcode is written back through the register memory port.
module mul_div_unit #(
  parameter int B = 32,
  parameter int N = 5
) (
  input logic     clk,
  input logic     rst_n,
  mul_div_if.slave bus
);
  localparam int CW = $clog2(B);
  localparam logic [CW-1:0] LAST_ITER = CW'(B - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_r;
  logic [CW-1:0]  cnt_r;
  logic [1:0]     op_r;
  logic [N-1:0]   rd_r;
  logic [B-1:0]   a_r;        // multiplicand
  logic [B-1:0]   b_r;        // divisor
  logic [2*B-1:0] acc_r;      // product accumulator; low half starts as multiplier
  logic [B-1:0]   quo_r;      // dividend shifting out, quotient shifting in
  logic [B:0]     rem_r;      // partial remainder
  logic           done_r;
  logic           we_r;
  logic [N-1:0]   w_addr_r;
  logic [B-1:0]   w_data_r;

  logic [B-1:0]   mcand_s;
  logic [B:0]     sum_s;
  logic [2*B-1:0] acc_next_s;
  logic [B:0]     rem_shift_s;
  logic [B:0]     diff_s;
  logic [B:0]     rem_next_s;
  logic           qbit_s;
  logic [B-1:0]   quo_next_s;
  logic [B-1:0]   result_s;

  function automatic logic [B-1:0] select_result(
    input logic [1:0]     op,
    input logic [2*B-1:0] prod,
    input logic [B-1:0]   quo,
    input logic [B-1:0]   rem
  );
    logic [B-1:0] res;
    case (op)
      2'b00:   res = prod[B-1:0];
      2'b01:   res = prod[2*B-1:B];
      2'b10:   res = quo;
      2'b11:   res = rem;
      default: res = prod[B-1:0];
    endcase
    return res;
  endfunction

  // One multiply step and one restoring-division step from the current state.
  always_comb begin
    mcand_s     = {B{1'b0}};
    qbit_s      = 1'b0;
    rem_next_s  = {(B+1){1'b0}};
    if (acc_r[0]) begin
      mcand_s = a_r;
    end else begin
      mcand_s = {B{1'b0}};
    end
    sum_s       = {1'b0, acc_r[2*B-1:B]} + {1'b0, mcand_s};
    acc_next_s  = {sum_s, acc_r[B-1:1]};
    // The remainder never exceeds B bits between steps, so the top bit drops out.
    rem_shift_s = (B+1)'({rem_r, quo_r[B-1]});
    diff_s      = rem_shift_s - {1'b0, b_r};
    // A zero divisor always "fits", yielding all-ones quotient and remainder = dividend.
    if (diff_s[B]) begin
      rem_next_s = rem_shift_s;
      qbit_s     = 1'b0;
    end else begin
      rem_next_s = diff_s;
      qbit_s     = 1'b1;
    end
    quo_next_s  = {quo_r[B-2:0], qbit_s};
    result_s    = select_result(op_r, acc_next_s, quo_next_s, rem_next_s[B-1:0]);
  end

  // Control FSM, datapath registers and registered writeback outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      cnt_r    <= {CW{1'b0}};
      op_r     <= 2'b00;
      rd_r     <= {N{1'b0}};
      a_r      <= {B{1'b0}};
      b_r      <= {B{1'b0}};
      acc_r    <= {(2*B){1'b0}};
      quo_r    <= {B{1'b0}};
      rem_r    <= {(B+1){1'b0}};
      done_r   <= 1'b0;
      we_r     <= 1'b0;
      w_addr_r <= {N{1'b0}};
      w_data_r <= {B{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          we_r   <= 1'b0;
          if (bus.start) begin
            op_r    <= bus.op;
            rd_r    <= bus.rd_addr;
            a_r     <= bus.rs_data1;
            b_r     <= bus.rs_data2;
            acc_r   <= {{B{1'b0}}, bus.rs_data2};
            quo_r   <= bus.rs_data1;
            rem_r   <= {(B+1){1'b0}};
            cnt_r   <= {CW{1'b0}};
            state_r <= S_RUN;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_r <= acc_next_s;
          quo_r <= quo_next_s;
          rem_r <= rem_next_s;
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == LAST_ITER) begin
            state_r  <= S_DONE;
            done_r   <= 1'b1;
            we_r     <= (rd_r != {N{1'b0}});
            w_addr_r <= rd_r;
            w_data_r <= result_s;
          end else begin
            state_r  <= S_RUN;
          end
        end
        S_DONE: begin
          done_r  <= 1'b0;
          we_r    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          we_r    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = (state_r != S_IDLE);
  assign bus.done     = done_r;
  assign bus.write_en = we_r;
  assign bus.w_addr   = w_addr_r;
  assign bus.w_data   = w_data_r;
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit with a small register-memory model.
module tb_mul_div_unit;
  localparam int B = 32;
  localparam int N = 5;

  typedef struct {
    logic [N-1:0] addr;
    logic [B-1:0] data;
    logic         we;
    int           e0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   wcount = 0;
  logic [B-1:0] regs [32] = '{default: 32'd0};
  exp_t sb [$];

  mul_div_if #(.B(B), .N(N)) bus ();

  mul_div_unit #(.B(B), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register memory model: commits writeback on the clock edge.
  always @(posedge clk) begin
    if (bus.write_en) begin
      regs[bus.w_addr] <= bus.w_data;
      wcount <= wcount + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [B-1:0] model(input logic [1:0] o, input logic [B-1:0] a, input logic [B-1:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (o)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      2'b11:   return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Completion monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (bus.write_en && !bus.done) check("we_without_done", 1, 0);
    if (bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("w_addr", bus.w_addr, e.addr);
        check("w_data", bus.w_data, e.data);
        check("write_en", bus.write_en, e.we);
        check("latency", cyc - e.e0, B);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [B-1:0] a, input logic [B-1:0] b,
                       input logic [N-1:0] rd, input logic [B-1:0] exp);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.rs_data1 = a; bus.rs_data2 = b; bus.rd_addr = rd;
    @(posedge clk); #1;
    check("accept_busy", bus.busy, 1);
    sb.push_back('{rd, exp, (rd != 5'd0), cyc});
    bus.start = 1'b0; bus.rs_data1 = 32'hDEAD_BEEF; bus.rs_data2 = 32'h1234_5678;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !bus.busy) break;
      @(posedge clk); #1;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    int wc;
    logic [1:0] o;
    logic [B-1:0] a, b;
    logic [N-1:0] rd;
    bus.start = 1'b0; bus.op = 2'b00; bus.rs_data1 = 32'd0; bus.rs_data2 = 32'd0; bus.rd_addr = 5'd0;
    #12;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_we", bus.write_en, 0);
    check("rst_w_addr", bus.w_addr, 0);
    check("rst_w_data", bus.w_data, 0);
    @(negedge clk); rst_n = 1'b1;

    issue(2'b00, 32'd7, 32'd6, 5'd3, 32'd42); wait_done();
    check("reg3_mul", regs[3], 42);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE); wait_done();
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0001); wait_done();
    issue(2'b10, 32'd100, 32'd7, 5'd6, 32'd14); wait_done();
    issue(2'b11, 32'd100, 32'd7, 5'd7, 32'd2); wait_done();
    issue(2'b10, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF); wait_done();
    issue(2'b11, 32'd5, 32'd0, 5'd10, 32'd5); wait_done();
    check("reg10_rem0", regs[10], 5);

    // Start while busy: request raised at E5 and held until accepted at E34.
    wc = wcount;
    issue(2'b00, 32'd7, 32'd6, 5'd3, 32'd42);
    repeat (4) @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 2'b00; bus.rs_data1 = 32'd9; bus.rs_data2 = 32'd9; bus.rd_addr = 5'd5;
    repeat (29) @(posedge clk); #1;
    check("busy_low_e33", bus.busy, 0);
    check("wcount_one", wcount - wc, 1);
    sb.push_back('{5'd5, 32'd81, 1'b1, cyc + 1});
    @(posedge clk); #1;
    check("accept_e34", bus.busy, 1);
    bus.start = 1'b0;
    wait_done();
    check("wcount_two", wcount - wc, 2);
    check("reg5_held", regs[5], 81);

    // Reset in the middle of a divide.
    issue(2'b10, 32'd100, 32'd7, 5'd9, 32'd14);
    repeat (10) @(posedge clk); #1;
    wc = wcount;
    rst_n = 1'b0; #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_we", bus.write_en, 0);
    check("abort_w_addr", bus.w_addr, 0);
    check("abort_w_data", bus.w_data, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk); #1;
    check("abort_reg9", regs[9], 0);
    check("abort_nowrite", wcount - wc, 0);
    issue(2'b00, 32'd3, 32'd4, 5'd4, 32'd12); wait_done();
    check("reg4_after_rst", regs[4], 12);

    // Destination x0: done pulses, no write.
    wc = wcount;
    issue(2'b00, 32'd2, 32'd2, 5'd0, 32'd4); wait_done();
    check("rd0_nowrite", wcount - wc, 0);
    check("reg0", regs[0], 0);

    // A few random operations against the arithmetic model.
    for (int k = 0; k < 6; k++) begin
      o  = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      rd = 5'($urandom_range(1, 31));
      issue(o, a, b, rd, model(o, a, b)); wait_done();
      check("rand_reg", regs[rd], model(o, a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
